// File: rtl/fifo_level_if.sv
// fifo_level handshake bundle: producer/consumer strobes, data and status.
// master drives requests, slave is the FIFO itself.
interface fifo_level_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             i_fifo_clr;
  logic             i_fifo_err_clr;
  logic             i_fifo_w_stb;
  logic [WIDTH-1:0] i_fifo_w_data;
  logic             o_fifo_full;
  logic             o_fifo_not_full;
  logic             o_fifo_almost_full;
  logic             i_fifo_r_stb;
  logic [WIDTH-1:0] o_fifo_r_data;
  logic             o_fifo_empty;
  logic             o_fifo_not_empty;
  logic             o_fifo_almost_empty;
  logic [CW-1:0]    o_fifo_count;
  logic             o_fifo_overflow;
  logic             o_fifo_underflow;

  modport master (
    output i_fifo_clr,
    output i_fifo_err_clr,
    output i_fifo_w_stb,
    output i_fifo_w_data,
    output i_fifo_r_stb,
    input  o_fifo_full,
    input  o_fifo_not_full,
    input  o_fifo_almost_full,
    input  o_fifo_r_data,
    input  o_fifo_empty,
    input  o_fifo_not_empty,
    input  o_fifo_almost_empty,
    input  o_fifo_count,
    input  o_fifo_overflow,
    input  o_fifo_underflow
  );

  modport slave (
    input  i_fifo_clr,
    input  i_fifo_err_clr,
    input  i_fifo_w_stb,
    input  i_fifo_w_data,
    input  i_fifo_r_stb,
    output o_fifo_full,
    output o_fifo_not_full,
    output o_fifo_almost_full,
    output o_fifo_r_data,
    output o_fifo_empty,
    output o_fifo_not_empty,
    output o_fifo_almost_empty,
    output o_fifo_count,
    output o_fifo_overflow,
    output o_fifo_underflow
  );
endinterface

// File: rtl/fifo_level.sv
// Synchronous FWFT FIFO, any DEPTH >= 2, with occupancy count,
// threshold flags, sticky over/underflow and synchronous flush.
module fifo_level #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 16,
  parameter int ALMOST_FULL  = DEPTH - 2,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fifo_level_if.slave  f
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef logic [PW-1:0] ptr_t;

  if (WIDTH < 1) begin : g_bad_width
    $error("fifo_level: WIDTH must be >= 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_level: DEPTH must be >= 2");
  end
  if (ALMOST_FULL < 1 || ALMOST_FULL > DEPTH) begin : g_bad_af
    $error("fifo_level: ALMOST_FULL out of 1..DEPTH");
  end
  if (ALMOST_EMPTY < 0 || ALMOST_EMPTY > DEPTH - 1) begin : g_bad_ae
    $error("fifo_level: ALMOST_EMPTY out of 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  logic [CW-1:0]    count;
  logic             ovf;
  logic             unf;

  logic full;
  logic empty;
  logic w_acc;
  logic r_acc;
  logic w_rej;
  logic r_rej;

  // Explicit wrap: DEPTH need not be a power of two.
  function automatic ptr_t inc(input ptr_t p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  assign w_acc = f.i_fifo_w_stb & ~full  & ~f.i_fifo_clr;
  assign r_acc = f.i_fifo_r_stb & ~empty & ~f.i_fifo_clr;
  assign w_rej = f.i_fifo_w_stb & full   & ~f.i_fifo_clr;
  assign r_rej = f.i_fifo_r_stb & empty  & ~f.i_fifo_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (f.i_fifo_clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (w_acc) wr_ptr <= inc(wr_ptr);
        if (r_acc) rd_ptr <= inc(rd_ptr);
        if (w_acc && !r_acc)
          count <= count + 1'b1;
        else if (r_acc && !w_acc)
          count <= count - 1'b1;
      end
      // A new rejection wins over a same-cycle clear.
      ovf <= w_rej | (ovf & ~f.i_fifo_err_clr);
      unf <= r_rej | (unf & ~f.i_fifo_err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_acc)
      mem[wr_ptr] <= f.i_fifo_w_data;
  end

  assign f.o_fifo_r_data       = mem[rd_ptr];
  assign f.o_fifo_count        = count;
  assign f.o_fifo_full         = full;
  assign f.o_fifo_not_full     = ~full;
  assign f.o_fifo_empty        = empty;
  assign f.o_fifo_not_empty    = ~empty;
  assign f.o_fifo_almost_full  = (count >= CW'(ALMOST_FULL));
  assign f.o_fifo_almost_empty = (count <= CW'(ALMOST_EMPTY));
  assign f.o_fifo_overflow     = ovf;
  assign f.o_fifo_underflow    = unf;
endmodule

// File: tb/tb_fifo_level.sv
// Bench for fifo_level: directed scenarios on DEPTH=5, random soak
// on DEPTH=16 and DEPTH=6 against a queue reference model.
module tb_fifo_level;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] q[$];
  bit m_ovf;
  bit m_unf;

  fifo_level_if #(.WIDTH(8), .DEPTH(5))  f5  ();
  fifo_level_if #(.WIDTH(8), .DEPTH(16)) f16 ();
  fifo_level_if #(.WIDTH(8), .DEPTH(6))  f6  ();

  fifo_level #(
    .WIDTH(8), .DEPTH(5), .ALMOST_FULL(4), .ALMOST_EMPTY(1)
  ) u5 (.clk(clk), .rst_n(rst_n), .f(f5.slave));

  fifo_level #(
    .WIDTH(8), .DEPTH(16)
  ) u16 (.clk(clk), .rst_n(rst_n), .f(f16.slave));

  fifo_level #(
    .WIDTH(8), .DEPTH(6)
  ) u6 (.clk(clk), .rst_n(rst_n), .f(f6.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int which, input logic w, input logic r,
                       input logic ec, input logic [7:0] d);
    case (which)
      16: begin
        f16.i_fifo_w_stb = w; f16.i_fifo_r_stb = r;
        f16.i_fifo_err_clr = ec; f16.i_fifo_w_data = d;
        f16.i_fifo_clr = 1'b0;
      end
      6: begin
        f6.i_fifo_w_stb = w; f6.i_fifo_r_stb = r;
        f6.i_fifo_err_clr = ec; f6.i_fifo_w_data = d;
        f6.i_fifo_clr = 1'b0;
      end
      default: begin
        f5.i_fifo_w_stb = w; f5.i_fifo_r_stb = r;
        f5.i_fifo_err_clr = ec; f5.i_fifo_w_data = d;
        f5.i_fifo_clr = 1'b0;
      end
    endcase
  endtask

  task automatic sample(input int which, output logic [31:0] cnt,
                        output logic emp, output logic ful,
                        output logic ae, output logic af,
                        output logic ov, output logic un,
                        output logic [7:0] dat);
    case (which)
      16: begin
        cnt = 32'(f16.o_fifo_count); emp = f16.o_fifo_empty;
        ful = f16.o_fifo_full; ae = f16.o_fifo_almost_empty;
        af = f16.o_fifo_almost_full; ov = f16.o_fifo_overflow;
        un = f16.o_fifo_underflow; dat = f16.o_fifo_r_data;
      end
      6: begin
        cnt = 32'(f6.o_fifo_count); emp = f6.o_fifo_empty;
        ful = f6.o_fifo_full; ae = f6.o_fifo_almost_empty;
        af = f6.o_fifo_almost_full; ov = f6.o_fifo_overflow;
        un = f6.o_fifo_underflow; dat = f6.o_fifo_r_data;
      end
      default: begin
        cnt = 32'(f5.o_fifo_count); emp = f5.o_fifo_empty;
        ful = f5.o_fifo_full; ae = f5.o_fifo_almost_empty;
        af = f5.o_fifo_almost_full; ov = f5.o_fifo_overflow;
        un = f5.o_fifo_underflow; dat = f5.o_fifo_r_data;
      end
    endcase
  endtask

  // Random strobes checked every cycle against the queue model.
  task automatic rand_run(input int which, input int n, input int depth,
                          input int afv, input int aev);
    logic w, r, ec;
    logic [7:0] d;
    logic [31:0] cnt;
    logic emp, ful, ae, af, ov, un;
    logic [7:0] dat;
    int wp = 2;
    int s;
    bit rw, rr;
    for (int k = 0; k < n; k++) begin
      if (k % 64 == 0) wp = int'($urandom_range(1, 3));
      w  = (int'($urandom_range(0, 3)) < wp);
      r  = (int'($urandom_range(0, 3)) < 4 - wp);
      ec = ($urandom_range(0, 31) == 0);
      d  = 8'($urandom);
      drive(which, w, r, ec, d);
      s  = q.size();
      rw = w && (s == depth);
      rr = r && (s == 0);
      if (r && s != 0) void'(q.pop_front());
      if (w && s != depth) q.push_back(d);
      m_ovf = rw | (m_ovf & !ec);
      m_unf = rr | (m_unf & !ec);
      step();
      sample(which, cnt, emp, ful, ae, af, ov, un, dat);
      n_chk++;
      if (cnt !== 32'(q.size())) begin
        n_fail++;
        $display("FAIL rand%0d_count cyc %0d got %0d want %0d",
                 which, k, cnt, q.size());
      end
      n_chk++;
      if (cnt > 32'(depth)) begin
        n_fail++;
        $display("FAIL rand%0d_range cyc %0d got %0d max %0d",
                 which, k, cnt, depth);
      end
      n_chk++;
      if ({emp, ful, ae, af} !== {q.size() == 0, q.size() == depth,
                                  q.size() <= aev, q.size() >= afv}) begin
        n_fail++;
        $display("FAIL rand%0d_flags cyc %0d got %b want %b", which, k,
                 {emp, ful, ae, af}, {q.size() == 0, q.size() == depth,
                                      q.size() <= aev, q.size() >= afv});
      end
      n_chk++;
      if ({ov, un} !== {m_ovf, m_unf}) begin
        n_fail++;
        $display("FAIL rand%0d_err cyc %0d got %b want %b",
                 which, k, {ov, un}, {m_ovf, m_unf});
      end
      if (q.size() != 0) begin
        n_chk++;
        if (dat !== q[0]) begin
          n_fail++;
          $display("FAIL rand%0d_data cyc %0d got %h want %h",
                   which, k, dat, q[0]);
        end
      end
    end
    drive(which, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(5, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(16, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(6, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) step();
    n_chk++;
    if (f5.o_fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_count got %0d want 0", f5.o_fifo_count);
    end
    n_chk++;
    if ({f5.o_fifo_empty, f5.o_fifo_not_empty, f5.o_fifo_full,
         f5.o_fifo_not_full} !== 4'b1001) begin
      n_fail++;
      $display("FAIL reset_emp_full got %b want 1001",
               {f5.o_fifo_empty, f5.o_fifo_not_empty,
                f5.o_fifo_full, f5.o_fifo_not_full});
    end
    n_chk++;
    if ({f5.o_fifo_almost_empty, f5.o_fifo_almost_full,
         f5.o_fifo_overflow, f5.o_fifo_underflow} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_misc got %b want 1000",
               {f5.o_fifo_almost_empty, f5.o_fifo_almost_full,
                f5.o_fifo_overflow, f5.o_fifo_underflow});
    end
    n_chk++;
    if ({f16.o_fifo_empty, f6.o_fifo_empty} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_others got %b want 11",
               {f16.o_fifo_empty, f6.o_fifo_empty});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 5; i++) begin
      drive(5, 1'b1, 1'b0, 1'b0, 8'(i * 17));
      step();
      n_chk++;
      if (f5.o_fifo_count !== 3'(i)) begin
        n_fail++;
        $display("FAIL fill_count got %0d want %0d", f5.o_fifo_count, i);
      end
      n_chk++;
      if ({f5.o_fifo_almost_empty, f5.o_fifo_almost_full, f5.o_fifo_full}
          !== {i <= 1, i >= 4, i == 5}) begin
        n_fail++;
        $display("FAIL fill_flags cnt %0d got %b want %b", i,
                 {f5.o_fifo_almost_empty, f5.o_fifo_almost_full,
                  f5.o_fifo_full}, {i <= 1, i >= 4, i == 5});
      end
      n_chk++;
      if (f5.o_fifo_r_data !== 8'h11) begin
        n_fail++;
        $display("FAIL fill_head got %h want 11", f5.o_fifo_r_data);
      end
    end
    drive(5, 1'b1, 1'b0, 1'b0, 8'h66);
    step();
    drive(5, 1'b0, 1'b0, 1'b0, 8'h00);
    n_chk++;
    if ({f5.o_fifo_overflow, f5.o_fifo_count} !== {1'b1, 3'd5}) begin
      n_fail++;
      $display("FAIL fill_overflow got ovf %b cnt %0d want ovf 1 cnt 5",
               f5.o_fifo_overflow, f5.o_fifo_count);
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 5; i++) begin
      n_chk++;
      if (f5.o_fifo_r_data !== 8'(i * 17)) begin
        n_fail++;
        $display("FAIL drain_data got %h want %h", f5.o_fifo_r_data,
                 8'(i * 17));
      end
      drive(5, 1'b0, 1'b1, 1'b0, 8'h00);
      step();
      n_chk++;
      if (f5.o_fifo_count !== 3'(5 - i)) begin
        n_fail++;
        $display("FAIL drain_count got %0d want %0d", f5.o_fifo_count,
                 5 - i);
      end
    end
    step();
    n_chk++;
    if ({f5.o_fifo_underflow, f5.o_fifo_count} !== {1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL drain_underflow got unf %b cnt %0d want unf 1 cnt 0",
               f5.o_fifo_underflow, f5.o_fifo_count);
    end
    drive(5, 1'b0, 1'b0, 1'b1, 8'h00);
    step();
    drive(5, 1'b0, 1'b0, 1'b0, 8'h00);
    n_chk++;
    if ({f5.o_fifo_overflow, f5.o_fifo_underflow} !== 2'b00) begin
      n_fail++;
      $display("FAIL err_clr got %b want 00",
               {f5.o_fifo_overflow, f5.o_fifo_underflow});
    end
  endtask

  task automatic test_simultaneous();
    drive(5, 1'b1, 1'b0, 1'b0, 8'hA1); step();
    drive(5, 1'b1, 1'b0, 1'b0, 8'hA2); step();
    drive(5, 1'b1, 1'b1, 1'b0, 8'hA3); step();
    n_chk++;
    if ({f5.o_fifo_count, f5.o_fifo_r_data} !== {3'd2, 8'hA2}) begin
      n_fail++;
      $display("FAIL simul_mid got cnt %0d data %h want cnt 2 data a2",
               f5.o_fifo_count, f5.o_fifo_r_data);
    end
    drive(5, 1'b0, 1'b1, 1'b0, 8'h00); step();
    n_chk++;
    if (f5.o_fifo_r_data !== 8'hA3) begin
      n_fail++;
      $display("FAIL simul_order got %h want a3", f5.o_fifo_r_data);
    end
    step();
    for (int i = 0; i < 5; i++) begin
      drive(5, 1'b1, 1'b0, 1'b0, 8'(8'hB1 + i));
      step();
    end
    drive(5, 1'b1, 1'b1, 1'b0, 8'hC0); step();
    n_chk++;
    if ({f5.o_fifo_count, f5.o_fifo_overflow, f5.o_fifo_r_data}
        !== {3'd4, 1'b1, 8'hB2}) begin
      n_fail++;
      $display("FAIL simul_full got cnt %0d ovf %b data %h want 4 1 b2",
               f5.o_fifo_count, f5.o_fifo_overflow, f5.o_fifo_r_data);
    end
    drive(5, 1'b0, 1'b1, 1'b0, 8'h00);
    repeat (4) step();
    drive(5, 1'b0, 1'b0, 1'b1, 8'h00); step();
    drive(5, 1'b1, 1'b1, 1'b0, 8'hD1); step();
    n_chk++;
    if ({f5.o_fifo_count, f5.o_fifo_underflow, f5.o_fifo_overflow,
         f5.o_fifo_r_data} !== {3'd1, 1'b1, 1'b0, 8'hD1}) begin
      n_fail++;
      $display("FAIL simul_empty got cnt %0d unf %b ovf %b data %h",
               f5.o_fifo_count, f5.o_fifo_underflow, f5.o_fifo_overflow,
               f5.o_fifo_r_data);
    end
    drive(5, 1'b0, 1'b1, 1'b1, 8'h00); step();
    drive(5, 1'b0, 1'b0, 1'b0, 8'h00);
    n_chk++;
    if ({f5.o_fifo_empty, f5.o_fifo_underflow} !== 2'b10) begin
      n_fail++;
      $display("FAIL simul_tail got %b want 10",
               {f5.o_fifo_empty, f5.o_fifo_underflow});
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(5, 1'b1, 1'b0, 1'b0, 8'(8'hE1 + i));
      step();
    end
    drive(5, 1'b1, 1'b0, 1'b0, 8'hAA);
    f5.i_fifo_clr = 1'b1;
    step();
    drive(5, 1'b0, 1'b0, 1'b0, 8'h00);
    n_chk++;
    if ({f5.o_fifo_count, f5.o_fifo_empty, f5.o_fifo_overflow,
         f5.o_fifo_underflow} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL flush got cnt %0d emp %b ovf %b unf %b",
               f5.o_fifo_count, f5.o_fifo_empty, f5.o_fifo_overflow,
               f5.o_fifo_underflow);
    end
    drive(5, 1'b1, 1'b0, 1'b0, 8'hBB); step();
    drive(5, 1'b0, 1'b0, 1'b0, 8'h00);
    n_chk++;
    if ({f5.o_fifo_count, f5.o_fifo_r_data} !== {3'd1, 8'hBB}) begin
      n_fail++;
      $display("FAIL flush_after got cnt %0d data %h want 1 bb",
               f5.o_fifo_count, f5.o_fifo_r_data);
    end
    drive(5, 1'b0, 1'b1, 1'b0, 8'h00); step();
    drive(5, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      drive(5, 1'b1, 1'b0, 1'b0, 8'(8'h31 + i));
      step();
    end
    drive(5, 1'b0, 1'b0, 1'b0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({f5.o_fifo_empty, f5.o_fifo_count} !== {1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL async_reset got emp %b cnt %0d want 1 0",
               f5.o_fifo_empty, f5.o_fifo_count);
    end
    step();
    rst_n = 1'b1;
    step();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    rand_run(5, 20, 5, 4, 1);
  endtask

  task automatic test_soak();
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    rand_run(16, 10000, 16, 14, 2);
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    rand_run(6, 10000, 6, 4, 2);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_flush();
    test_async_reset();
    test_soak();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
